// File: rtl/vga_timing_pkg.sv
// Shared VGA raster definitions: axis phase encoding, default 640x480@60 timing
// and a small half-open range compare used by the window decode.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FRONT;

  // lo <= v < hi, evaluated at 11 bits so hi may exceed the 10-bit count range
  function automatic logic in_range(input logic [10:0] v, input logic [10:0] lo,
                                    input logic [10:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
// count_nxt and wrap are the values that will be loaded on the coming edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FRONT_LEN  = DEF_H_FRONT,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BACK_LEN   = DEF_H_BACK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adv,
  output logic [9:0] count,
  output logic [9:0] count_nxt,
  output phase_t     phase,
  output logic       wrap,
  output logic       in_sync
);

  phase_t     phase_r;
  logic [9:0] ph_cnt_r;
  logic [9:0] count_r;
  logic       in_sync_r;
  logic       last_s;
  logic [9:0] count_nxt_s;

  function automatic logic [9:0] phase_last(input phase_t p);
    case (p)
      ACTIVE:  return 10'(ACTIVE_LEN - 1);
      FRONT:   return 10'(FRONT_LEN - 1);
      SYNC:    return 10'(SYNC_LEN - 1);
      BACK:    return 10'(BACK_LEN - 1);
      default: return 10'(ACTIVE_LEN - 1);
    endcase
  endfunction

  // End-of-phase detect, axis wrap and next position
  always_comb begin
    last_s = (ph_cnt_r == phase_last(phase_r));
    wrap   = adv && (phase_r == BACK) && last_s;
    if (wrap) begin
      count_nxt_s = 10'd0;
    end else if (adv) begin
      count_nxt_s = count_r + 10'd1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Phase FSM; in_sync is loaded from the phase being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r   <= ACTIVE;
      ph_cnt_r  <= 10'd0;
      count_r   <= 10'd0;
      in_sync_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (adv && last_s) begin
        ph_cnt_r <= 10'd0;
        case (phase_r)
          ACTIVE:  begin phase_r <= FRONT;  in_sync_r <= 1'b0; end
          FRONT:   begin phase_r <= SYNC;   in_sync_r <= 1'b1; end
          SYNC:    begin phase_r <= BACK;   in_sync_r <= 1'b0; end
          BACK:    begin phase_r <= ACTIVE; in_sync_r <= 1'b0; end
          default: begin phase_r <= ACTIVE; in_sync_r <= 1'b0; end
        endcase
      end else if (adv) begin
        ph_cnt_r <= ph_cnt_r + 10'd1;
      end else begin
        ph_cnt_r <= ph_cnt_r;
      end
    end
  end

  assign count     = count_r;
  assign count_nxt = count_nxt_s;
  assign phase     = phase_r;
  assign in_sync   = in_sync_r;

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster timing: pixel enable divider, H/V axis counters, active-low syncs,
// active-area flag, write-window strobe and frame tick, all cycle-aligned with the counters.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int PIX_DIV  = 1,
  parameter int WIN_H0   = 97,
  parameter int WIN_V0   = 206,
  parameter int WIN_W    = 448,
  parameter int WIN_HT   = 70
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] counter1,
  output logic [9:0] counter2,
  output logic       hsync,
  output logic       vsync,
  output logic       write,
  output logic       active,
  output logic       frame_tick
);

  localparam logic [10:0] WIN_H_LO = 11'(WIN_H0);
  localparam logic [10:0] WIN_H_HI = 11'(WIN_H0 + WIN_W);
  localparam logic [10:0] WIN_V_LO = 11'(WIN_V0);
  localparam logic [10:0] WIN_V_HI = 11'(WIN_V0 + WIN_HT);
  localparam logic [10:0] H_ACT_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_LIM = 11'(V_ACTIVE);

  logic       div_r;
  logic       pe_s;
  logic [9:0] h_count_s, h_nxt_s, v_count_s, v_nxt_s;
  phase_t     h_phase_s, v_phase_s;
  logic       h_wrap_s, v_wrap_s, h_in_sync_s, v_in_sync_s;
  logic       active_nxt_s, write_nxt_s;
  logic       write_r, frame_tick_r;

  // Free-running pixel divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= 1'b0;
    end else begin
      div_r <= ~div_r;
    end
  end

  // Pixel enable select
  always_comb begin
    if (PIX_DIV == 2) begin
      pe_s = div_r;
    end else begin
      pe_s = 1'b1;
    end
  end

  vga_axis_counter #(
    .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
  ) u_h_axis (
    .clk(clk), .reset(reset), .adv(pe_s),
    .count(h_count_s), .count_nxt(h_nxt_s), .phase(h_phase_s),
    .wrap(h_wrap_s), .in_sync(h_in_sync_s)
  );

  vga_axis_counter #(
    .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
  ) u_v_axis (
    .clk(clk), .reset(reset), .adv(h_wrap_s),
    .count(v_count_s), .count_nxt(v_nxt_s), .phase(v_phase_s),
    .wrap(v_wrap_s), .in_sync(v_in_sync_s)
  );

  // Window decode on the position about to be presented; clipped by the active area
  always_comb begin
    active_nxt_s = ({1'b0, h_nxt_s} < H_ACT_LIM) && ({1'b0, v_nxt_s} < V_ACT_LIM);
    write_nxt_s  = in_range({1'b0, h_nxt_s}, WIN_H_LO, WIN_H_HI) &&
                   in_range({1'b0, v_nxt_s}, WIN_V_LO, WIN_V_HI) && active_nxt_s;
  end

  // Window strobe and frame tick registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_r      <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      write_r      <= write_nxt_s;
      frame_tick_r <= v_wrap_s;
    end
  end

  assign counter2   = h_count_s;
  assign counter1   = v_count_s;
  assign hsync      = ~h_in_sync_s;
  assign vsync      = ~v_in_sync_s;
  assign active     = (h_phase_s == ACTIVE) && (v_phase_s == ACTIVE);
  assign write      = write_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Four raster generators (default timing, shrunk timing at PIX_DIV 1 and 2, clipped window)
// checked every clk against an arithmetic raster model, with random async resets.
module tb_vga_sync_generator;

  typedef struct {
    int pd, ha, hf, hs, hb, va, vf, vs, vb, h0, w, v0, ht;
  } cfg_t;

  typedef struct {
    int c1, c2, hs, vs, wr, act, ft;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   k = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  cfg_t ca, cb, cc, cd;

  logic [9:0] a_c1, a_c2, b_c1, b_c2, c_c1, c_c2, d_c1, d_c2;
  logic a_hs, a_vs, a_wr, a_act, a_ft;
  logic b_hs, b_vs, b_wr, b_act, b_ft;
  logic c_hs, c_vs, c_wr, c_act, c_ft;
  logic d_hs, d_vs, d_wr, d_act, d_ft;

  always #5 clk = ~clk;

  vga_sync_generator u_a (
    .clk(clk), .reset(reset), .counter1(a_c1), .counter2(a_c2), .hsync(a_hs),
    .vsync(a_vs), .write(a_wr), .active(a_act), .frame_tick(a_ft));

  vga_sync_generator #(
    .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5), .V_ACTIVE(12), .V_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .PIX_DIV(1), .WIN_H0(5), .WIN_V0(4), .WIN_W(8), .WIN_HT(3)
  ) u_b (
    .clk(clk), .reset(reset), .counter1(b_c1), .counter2(b_c2), .hsync(b_hs),
    .vsync(b_vs), .write(b_wr), .active(b_act), .frame_tick(b_ft));

  vga_sync_generator #(
    .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5), .V_ACTIVE(12), .V_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .PIX_DIV(2), .WIN_H0(5), .WIN_V0(4), .WIN_W(8), .WIN_HT(3)
  ) u_c (
    .clk(clk), .reset(reset), .counter1(c_c1), .counter2(c_c2), .hsync(c_hs),
    .vsync(c_vs), .write(c_wr), .active(c_act), .frame_tick(c_ft));

  vga_sync_generator #(
    .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5), .V_ACTIVE(12), .V_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .PIX_DIV(1), .WIN_H0(15), .WIN_V0(10), .WIN_W(10), .WIN_HT(5)
  ) u_d (
    .clk(clk), .reset(reset), .counter1(d_c1), .counter2(d_c2), .hsync(d_hs),
    .vsync(d_vs), .write(d_wr), .active(d_act), .frame_tick(d_ft));

  // Raster position after k clk edges since reset, derived from pixel index arithmetic
  function automatic exp_t model(input cfg_t c, input int kk);
    exp_t e;
    int htot, vtot, p, x, y;
    htot = c.ha + c.hf + c.hs + c.hb;
    vtot = c.va + c.vf + c.vs + c.vb;
    p = kk / c.pd;
    x = p % htot;
    y = (p / htot) % vtot;
    e.c2  = x;
    e.c1  = y;
    e.hs  = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? 0 : 1;
    e.vs  = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? 0 : 1;
    e.act = (x < c.ha && y < c.va) ? 1 : 0;
    e.wr  = (e.act == 1 && x >= c.h0 && x < c.h0 + c.w && y >= c.v0 && y < c.v0 + c.ht) ? 1 : 0;
    e.ft  = (kk > 0 && kk % c.pd == 0 && p % (htot * vtot) == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_miss++;
      $display("FAIL %s at k=%0d: got %0d, expected %0d", tag, k, obs, want);
    end
  endtask

  task automatic cmp_inst(input string nm, input cfg_t c, input logic [9:0] c1,
                          input logic [9:0] c2, input logic hs, input logic vs,
                          input logic wr, input logic act, input logic ft);
    exp_t e;
    e = model(c, k);
    check({nm, ".counter1"}, 32'(c1), 32'(e.c1));
    check({nm, ".counter2"}, 32'(c2), 32'(e.c2));
    check({nm, ".hsync"}, 32'(hs), 32'(e.hs));
    check({nm, ".vsync"}, 32'(vs), 32'(e.vs));
    check({nm, ".write"}, 32'(wr), 32'(e.wr));
    check({nm, ".active"}, 32'(act), 32'(e.act));
    check({nm, ".frame_tick"}, 32'(ft), 32'(e.ft));
  endtask

  task automatic cmp_all();
    cmp_inst("a", ca, a_c1, a_c2, a_hs, a_vs, a_wr, a_act, a_ft);
    cmp_inst("b", cb, b_c1, b_c2, b_hs, b_vs, b_wr, b_act, b_ft);
    cmp_inst("c", cc, c_c1, c_c2, c_hs, c_vs, c_wr, c_act, c_ft);
    cmp_inst("d", cd, d_c1, d_c2, d_hs, d_vs, d_wr, d_act, d_ft);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) k++;
    @(negedge clk);
    cmp_all();
  endtask

  // Async reset between edges: outputs must return to reset values before any edge
  task automatic mid_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    k = 0;
    #1;
    cmp_all();
    @(negedge clk);
    cmp_all();
    reset = 1'b0;
  endtask

  initial begin
    int a_hs_low, c_wr_clks, d_wr_clks, b_ticks, len;
    ca = '{1, 640, 16, 96, 48, 480, 10, 2, 33, 97, 448, 206, 70};
    cb = '{1, 20, 3, 4, 5, 12, 2, 2, 3, 5, 8, 4, 3};
    cc = '{2, 20, 3, 4, 5, 12, 2, 2, 3, 5, 8, 4, 3};
    cd = '{1, 20, 3, 4, 5, 12, 2, 2, 3, 15, 10, 10, 5};
    a_hs_low = 0;
    c_wr_clks = 0;
    d_wr_clks = 0;
    b_ticks = 0;

    @(negedge clk);
    cmp_all();
    reset = 1'b0;

    for (int i = 1; i <= 1700; i++) begin
      step();
      if (i <= 800)  a_hs_low  += (a_hs == 1'b0) ? 1 : 0;
      if (i <= 1216) c_wr_clks += (c_wr == 1'b1) ? 1 : 0;
      if (i <= 608)  d_wr_clks += (d_wr == 1'b1) ? 1 : 0;
      b_ticks += (b_ft == 1'b1) ? 1 : 0;
    end
    check("a_hsync_low_clks_per_line", 32'(a_hs_low), 32'd96);
    check("c_write_clks_per_frame", 32'(c_wr_clks), 32'd48);
    check("d_clipped_write_clks_per_frame", 32'(d_wr_clks), 32'd10);
    check("b_frame_ticks_in_1700", 32'(b_ticks), 32'd2);

    for (int s = 0; s < 6; s++) begin
      mid_reset();
      len = int'($urandom_range(100, 900));
      for (int i = 0; i < len; i++) begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

- Drives the VGA raster: horizontal/vertical pixel counters, active-low hsync/vsync, and a `write` window strobe.
- Sits upstream of the cronometer RGB controller, which consumes `counter1`, `counter2` and `write` to paint digits.
- Default timing is 640x480@60 Hz from a pixel-rate clock; an optional divider supports a 2x system clock.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16 / `H_SYNC`, 96 / `H_BACK`, 48: horizontal porch/sync lengths in pixels (total 800)
- `V_ACTIVE`, 480 / `V_FRONT`, 10 / `V_SYNC`, 2 / `V_BACK`, 33: vertical lengths in lines (total 525)
- `PIX_DIV`, 1, clk cycles per pixel (1 or 2)
- `WIN_H0`, 97 / `WIN_V0`, 206: first column/line of the write window
- `WIN_W`, 448 / `WIN_HT`, 70: window width/height in pixels (8 glyphs x 4 x 14, 5 x 14)
- `clk` in 1: single system clock
- `reset` in 1: asynchronous, active-high reset
- `counter1` out 10: vertical counter, 0..524
- `counter2` out 10: horizontal counter, 0..799
- `hsync` out 1: active low
- `vsync` out 1: active low
- `write` out 1: high while (`counter2`, `counter1`) is inside the window and inside the active area
- `active` out 1: high while `counter2` < `H_ACTIVE` and `counter1` < `V_ACTIVE`
- `frame_tick` out 1: one-clk pulse when the raster wraps to (0,0)

## Operation
- Pixel enable `pe`:
  - `PIX_DIV`=1: `pe` is constant 1.
  - `PIX_DIV`=2: a 1-bit divider toggles every clk, and `pe` is high when the divider is 1.
- On `pe`, `counter2` increments and wraps from 799 to 0. At that wrap, `counter1` increments and wraps from 524 to 0.
- Per-axis phase FSM:
  - States: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Each transition happens when the in-phase count reaches its parameter length minus 1.
  - The vertical FSM advances only on horizontal wrap.
- Sync outputs:
  - `hsync` = 0 exactly while the horizontal FSM is in SYNC, i.e. `counter2` 656..751.
  - `vsync` = 0 exactly while the vertical FSM is in SYNC, i.e. `counter1` 490..491.
- Window:
  - `write` = (WIN_V0 <= `counter1` < WIN_V0+WIN_HT) and (WIN_H0 <= `counter2` < WIN_H0+WIN_W) and `active`.
  - Bounds use 11-bit arithmetic, so WIN_H0+WIN_W may exceed 1023 without wrap.
  - A window extending past the active area is clipped, never wrapped.
- `frame_tick` is high for the clk cycle in which the counters read (0,0) after a wrap. It is not asserted out of reset.

## Timing
- All outputs are registered and updated on the same clk edge. `hsync`, `vsync`, `write` and `active` are decoded from next-state values, so they are always consistent with the `counter1`/`counter2` values presented in the same cycle (0-cycle skew).
- Reset values: `counter1`=0, `counter2`=0, `hsync`=1, `vsync`=1, `write`=0, `active`=1, `frame_tick`=0. Divider=0, both FSMs in ACTIVE.
- First `pe` after reset release:
  - `PIX_DIV`=1: first clk edge.
  - `PIX_DIV`=2: second clk edge.
- Output hold per pixel:
  - Each counter value is held for exactly `PIX_DIV` clk cycles.
  - `write` is high for WIN_W x `PIX_DIV` consecutive clks per window line.
- Reset asserted mid-frame forces all reset values immediately (async). The raster restarts from (0,0) with no partial sync pulse.
- Line and frame wrap on the same `pe` (799,524 -> 0,0): both counters update in one edge, and `frame_tick` fires.

## Structure
- Package `vga_timing_pkg`:
  - `phase_t` enum {ACTIVE, FRONT, SYNC, BACK}.
  - Default 640x480 timing constants.
  - Derived `H_TOTAL`/`V_TOTAL` and sync-start constants.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal, vertical):
  - Parameters: lengths.
  - Inputs: `clk`, `reset`, `adv`.
  - Outputs: count, phase, wrap, in_sync.
- Top level contains the divider, window compare, `frame_tick` and output registers.

## Test plan
- Reset, release, `PIX_DIV`=1, run 800 clks:
  - `counter2` reaches 799 then 0, and `counter1` becomes 1.
  - `hsync` low for exactly 96 clks starting at `counter2`=656.
- Run a full frame:
  - `vsync` low exactly on lines 490 and 491.
  - `frame_tick` pulses once at 420000 clks.
- Window check:
  - `write` rises at (206,97), stays high 448 clks per line for lines 206..275, and is low at `counter2`=545.
- `PIX_DIV`=2:
  - Every counter value is held 2 clks.
  - `write` high 896 clks per window line; one frame = 840000 clks.
- Clipping: WIN_H0=600, WIN_W=100 -> `write` high only for `counter2` 600..639, and never during blanking.
- Reset asserted at (300,400) -> next sampled outputs are (0,0), `hsync`=`vsync`=1, `write`=0, with no spurious `frame_tick`.
